// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the OpenRAM port-0 read/write controller.
// Targets the 1 KB macro: 256 words of 32 bits with a per-byte write mask.
package sram_ctrl_pkg;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;
  localparam int DEF_RSP_DEPTH  = 2;
  localparam bit DEF_INIT_ZERO  = 1'b1;

  // Bits needed to hold an occupancy value from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rw_port_ctrl_rsp_fifo.sv
// Circular response buffer for read data returned by the macro.
// Push and pop may occur together at any occupancy; head is always the oldest entry.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_RSP_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [DATA_WIDTH-1:0]          head,
  output logic                           empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL_CNT) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Request/response initiator for port 0 of the OpenRAM 32x256 macro, with optional
// post-reset zero-fill and credit-based protection of the response buffer.
module sram_rw_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter bit INIT_ZERO  = DEF_INIT_ZERO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int CW = count_width(RSP_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = '1;
  localparam logic [CW:0]           CREDIT_LIMIT = (CW+1)'(RSP_DEPTH);

  state_e                state;
  state_e                state_next;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [ADDR_WIDTH-1:0] init_addr_next;
  logic                  rd_pend;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  rsp_pop;
  logic                  req_fire;
  logic                  read_fire;
  logic [CW:0]           credits_used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_ZERO ? S_INIT : S_RUN;
      init_addr <= '0;
    end else begin
      state     <= state_next;
      init_addr <= init_addr_next;
    end
  end

  always_comb begin
    state_next     = state;
    init_addr_next = init_addr;
    case (state)
      S_INIT: begin
        init_addr_next = init_addr + ADDR_WIDTH'(1);
        if (init_addr == LAST_ADDR) begin
          state_next = S_RUN;
        end
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = state;
    endcase
  end

  // A head entry popped this cycle frees its slot in time for a read issued now,
  // which is what lets a depth-2 buffer sustain one read per cycle.
  always_comb begin
    rsp_pop      = rsp_valid && rsp_ready;
    credits_used = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend} - {{CW{1'b0}}, rsp_pop};
  end

  always_comb begin
    req_ready = 1'b0;
    if (rst_n && (state == S_RUN)) begin
      req_ready = req_we || (credits_used < CREDIT_LIMIT);
    end
  end

  always_comb begin
    req_fire  = req_valid && req_ready;
    read_fire = req_fire && !req_we;
  end

  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (rst_n) begin
      case (state)
        S_INIT: begin
          csb0   = 1'b0;
          web0   = 1'b0;
          wmask0 = '1;
          addr0  = init_addr;
        end
        S_RUN: begin
          if (req_fire) begin
            csb0  = 1'b0;
            web0  = !req_we;
            addr0 = req_addr;
            if (req_we) begin
              wmask0 = req_wmask;
              din0   = req_wdata;
            end
          end
        end
        default: csb0 = 1'b1;
      endcase
    end
  end

  // dout0 is valid the cycle after a read is issued; rd_pend marks that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= read_fire;
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend),
    .push_data (dout0),
    .pop       (rsp_pop),
    .count     (fifo_count),
    .head      (rsp_rdata),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign init_done = rst_n && (state == S_RUN);

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Bench for sram_rw_port_ctrl: behavioural SRAM macro, reference memory and response
// queue model, a per-cycle compare process, and directed scenarios with literal checks.
module tb_sram_rw_port_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NW    = 4;
  localparam int RD    = 2;
  localparam int WORDS = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [NW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          csb0;
  logic          web0;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = 32'hBAD0BAD0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sram_rw_port_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_WMASKS (NW),
    .RSP_DEPTH  (RD),
    .INIT_ZERO  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wmask (req_wmask),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .csb0      (csb0),
    .web0      (web0),
    .wmask0    (wmask0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  // Macro model: garbage contents at power-up, synchronous write/read, dout next cycle.
  logic [DW-1:0] ram [WORDS];
  logic          ram_seeded = 1'b0;

  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < WORDS; i++) begin
        ram[i] <= (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
      end
      ram_seeded <= 1'b1;
    end else if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < NW; b++) begin
          if (wmask0[b]) ram[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end
      end else begin
        dout0 <= ram[addr0];
      end
    end
  end

  // Reference model: zero-filled memory after each reset, queue of expected responses.
  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] refmem [WORDS];
  int            tick = 0;
  int            init_cyc = 0;

  function automatic bit m_rsp_valid();
    if (!rst_n) return 1'b0;
    if (q.size() == 0) return 1'b0;
    return tick >= q[0].avail;
  endfunction

  function automatic bit m_ready();
    int inflight;
    if (!rst_n || init_cyc < WORDS) return 1'b0;
    if (req_we) return 1'b1;
    inflight = q.size() - ((m_rsp_valid() && rsp_ready) ? 1 : 0);
    return inflight < RD;
  endfunction

  always @(posedge clk) begin
    bit fire;
    bit pop;
    if (!rst_n) begin
      q.delete();
      init_cyc <= 0;
      for (int i = 0; i < WORDS; i++) refmem[i] <= '0;
    end else begin
      fire = req_valid && m_ready();
      pop  = m_rsp_valid() && rsp_ready;
      if (pop) void'(q.pop_front());
      if (fire) begin
        if (req_we) begin
          for (int b = 0; b < NW; b++) begin
            if (req_wmask[b]) refmem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
          end
        end else begin
          q.push_back('{data: refmem[req_addr], avail: tick + 2});
        end
      end
      if (init_cyc < WORDS) init_cyc <= init_cyc + 1;
    end
    tick <= tick + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  always @(negedge clk) begin
    bit fire;
    if (!rst_n) begin
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("rst_init_done", 32'(init_done), 32'd0);
      checkOutput("rst_csb0", 32'(csb0), 32'd1);
      checkOutput("rst_web0", 32'(web0), 32'd1);
      checkOutput("rst_wmask0", 32'(wmask0), 32'd0);
      checkOutput("rst_addr0", 32'(addr0), 32'd0);
      checkOutput("rst_din0", din0, 32'd0);
    end else if (init_cyc < WORDS) begin
      checkOutput("init_init_done", 32'(init_done), 32'd0);
      checkOutput("init_req_ready", 32'(req_ready), 32'd0);
      checkOutput("init_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("init_csb0", 32'(csb0), 32'd0);
      checkOutput("init_web0", 32'(web0), 32'd0);
      checkOutput("init_wmask0", 32'(wmask0), 32'hF);
      checkOutput("init_din0", din0, 32'd0);
      checkOutput("init_addr0", 32'(addr0), 32'(init_cyc));
    end else begin
      fire = req_valid && m_ready();
      checkOutput("run_init_done", 32'(init_done), 32'd1);
      checkOutput("run_req_ready", 32'(req_ready), 32'(m_ready()));
      checkOutput("run_rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid()));
      if (m_rsp_valid()) checkOutput("run_rsp_rdata", rsp_rdata, q[0].data);
      checkOutput("run_csb0", 32'(csb0), 32'(!fire));
      checkOutput("run_web0", 32'(web0), 32'(fire ? !req_we : 1'b1));
      checkOutput("run_addr0", 32'(addr0), 32'(fire ? req_addr : '0));
      checkOutput("run_wmask0", 32'(wmask0), 32'((fire && req_we) ? req_wmask : '0));
      checkOutput("run_din0", din0, (fire && req_we) ? req_wdata : 32'd0);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [NW-1:0] mask,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_valid = valid;
    req_we    = we;
    req_wmask = mask;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic doReq(input logic we, input logic [NW-1:0] mask, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    bit acc = 1'b0;
    applyStimulus(1'b1, we, mask, addr, wdata);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
      stepCycle();
    end
    if (!acc) checkOutput("req_accept_timeout", 32'd0, 32'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Issues a read, then reports the accept-to-rsp_valid latency and the data presented.
  task automatic doRead(input logic [AW-1:0] addr, output int lat, output logic [DW-1:0] data);
    lat = 0;
    data = '0;
    doReq(1'b0, '0, addr, '0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        data = rsp_rdata;
        break;
      end
    end
    stepCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            n;
    int            lat;
    int            idx;
    int            hs;
    logic [DW-1:0] data;

    rsp_ready = 1'b1;
    repeat (3) stepCycle();
    rst_n = 1'b1;

    // Zero-fill sweep: count cycles whose pins match the expected fill word.
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (init_done) break;
      if (!csb0 && !web0 && wmask0 == 4'hF && din0 == '0 && addr0 == n[AW-1:0]) n++;
    end
    checkOutput("init_cycles", 32'(n), 32'd256);
    stepCycle();

    doRead(8'h17, lat, data);
    checkOutput("rd17_data", data, 32'h0);

    doReq(1'b1, 4'b0101, 8'h10, 32'hDEADBEEF);
    doRead(8'h10, lat, data);
    checkOutput("rd10_latency", 32'(lat), 32'd2);
    checkOutput("rd10_data", data, 32'h00AD00EF);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 4'hF, AW'(i), 32'hC0DE0000 | (i * 32'h0101));
      stepCycle();
    end

    // Back-to-back reads with the consumer always ready.
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) applyStimulus(1'b1, 1'b0, '0, AW'(i), '0);
      else applyStimulus(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      if (i < 16) checkOutput("b2b_req_ready", 32'(req_ready), 32'd1);
      if (rsp_valid && rsp_ready) hs++;
      stepCycle();
    end
    checkOutput("b2b_rsp_count", 32'(hs), 32'd16);

    // Backpressure: two reads fit, the third waits, a write still goes through.
    rsp_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(idx), '0);
      @(negedge clk);
      if (req_ready) idx++;
      stepCycle();
    end
    checkOutput("bp_accepted", 32'(idx), 32'd2);
    @(negedge clk);
    checkOutput("bp_read_blocked", 32'(req_ready), 32'd0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 4'hF, 8'h40, 32'h12345678);
    @(negedge clk);
    checkOutput("bp_write_ready", 32'(req_ready), 32'd1);
    stepCycle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(idx), '0);
      @(negedge clk);
      if (i == 0) checkOutput("bp_first_rsp", rsp_rdata, 32'hC0DE0000);
      if (req_ready) idx++;
      stepCycle();
    end
    checkOutput("bp_all_accepted", 32'(idx), 32'd4);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    repeat (4) stepCycle();

    // Streaming reads with one pop per push: occupancy sits at one entry.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(i + 4), '0);
      @(negedge clk);
      checkOutput("pp_req_ready", 32'(req_ready), 32'd1);
      if (i >= 2 && i < 12) checkOutput("pp_fifo_count", 32'(dut.fifo_count), 32'd1);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    repeat (4) stepCycle();

    // Reset with a response buffered and another read in flight.
    rsp_ready = 1'b0;
    doReq(1'b0, '0, 8'h10, '0);
    doReq(1'b0, '0, 8'h11, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_csb0", 32'(csb0), 32'd1);
    repeat (2) stepCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("refill_addr0", 32'(addr0), 32'd0);
    checkOutput("refill_csb0", 32'(csb0), 32'd0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (init_done) break;
    end
    stepCycle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("no_stale_rsp", 32'(rsp_valid), 32'd0);
      stepCycle();
    end
    doRead(8'h10, lat, data);
    checkOutput("refill_rd10_data", data, 32'h0);
    repeat (3) stepCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
